mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clock port clk SHALL be the single clock; every register samples on its rising edge.
REQ-002 Reset port rst SHALL be synchronous and active-high.
REQ-003 ctlwb_in  input  2  SHALL carry the writeback control bits, passed through to MEM/WB.
REQ-004 ctlm_in  input  2  SHALL carry the memory control bits: bit1 = memread, bit0 = memwrite.
REQ-005 alu_result_in  input  32  SHALL carry the byte address for a load or store, and the ALU result for pass-through.
REQ-006 rdata2_in  input  32  SHALL carry the store data.
REQ-007 muxout_in  input  5  SHALL carry the destination register number.
REQ-008 ctlwb_out  output  2  SHALL be the registered writeback control.
REQ-009 read_data_out  output  32  SHALL be the registered load data.
REQ-010 alu_result_out  output  32  SHALL be the registered alu_result_in.
REQ-011 muxout_out  output  5  SHALL be the registered muxout_in.
REQ-012 misalign_out  output  1  SHALL be a registered flag marking a misaligned access.
REQ-013 load_cnt, store_cnt  output  16 each  SHALL be access counters, present only under MEM_ACCESS_CNT_EN.

Function
REQ-014 Data memory SHALL be 256 x 32-bit words, indexed by alu_result_in[9:2]; bits [31:10] SHALL be ignored (aliasing/wrap).
REQ-015 An access SHALL be aligned iff alu_result_in[1:0] == 2'b00.
REQ-016 On an aligned cycle with memwrite=1, rdata2_in SHALL be written to the indexed word at the clock edge.
REQ-017 On an aligned cycle with memread=1, the indexed word SHALL be latched into read_data_out at the same edge, giving 1-cycle latency.
REQ-018 With memread=0, read_data_out SHALL latch 32'h0.
REQ-019 If memread=1 and memwrite=1 in the same cycle, the read SHALL return the pre-write content, and the write SHALL complete.
REQ-020 On a misaligned cycle with memread or memwrite set:
- the write SHALL be suppressed;
- read_data_out SHALL latch 0;
- ctlwb_out SHALL latch 2'b00;
- misalign_out SHALL latch 1.
REQ-021 In all other cycles misalign_out SHALL latch 0, and ctlwb_out, alu_result_out and muxout_out SHALL latch their inputs unmodified.
REQ-022 The MEM/WB latch SHALL update every cycle; there is no stall or enable.

Reset
REQ-023 When rst=1 at an edge:
- ctlwb_out, read_data_out, alu_result_out, muxout_out and misalign_out SHALL become 0;
- counters SHALL become 0.
REQ-024 rst SHALL take priority over memwrite: no memory write occurs on a reset cycle.
REQ-025 Memory contents SHALL NOT be altered by reset.
REQ-026 A reset asserted mid-sequence SHALL discard the in-flight latch contents; the first post-reset cycle SHALL behave as a normal cycle.

Configuration
REQ-027 Macro MEM_ACCESS_CNT_EN defined: load_cnt SHALL increment once per aligned memread cycle, and store_cnt once per aligned memwrite cycle.
- Both SHALL increment if both bits are set.
- Each SHALL saturate at 16'hFFFF.
- Neither SHALL count misaligned cycles or reset cycles.
REQ-028 Macro MEM_ACCESS_CNT_EN undefined: the load_cnt and store_cnt ports and registers SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-029 Store then load: write 32'hDEADBEEF to address 0x10, then read 0x10 on the next cycle -> read_data_out = 32'hDEADBEEF one edge after the read; ctlwb_out = ctlwb_in.
REQ-030 Same-cycle read/write: word 0x20 holds 32'h1111_1111; read+write 32'h2222_2222 to 0x20 -> read_data_out = 32'h1111_1111; a following read returns 32'h2222_2222.
REQ-031 Misaligned store: memwrite to 0x13 with data 32'hA5A5A5A5, ctlwb_in = 2'b11 -> misalign_out = 1 and ctlwb_out = 2'b00; a later aligned read of 0x10 returns the prior value unchanged.
REQ-032 Aliasing: write 32'h0000_00FF to 0x404 -> an aligned read of 0x004 returns 32'h0000_00FF.
REQ-033 Reset mid-operation: load in flight with rst=1 at the next edge -> all latch outputs = 0 and counters = 0; memory word retained; no write during rst even if memwrite=1.
REQ-034 Counter saturation (MEM_ACCESS_CNT_EN): 65540 aligned loads -> load_cnt = 16'hFFFF; store_cnt = 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: 256x32 data memory with alignment check and MEM/WB latch.
// Optional load/store access counters when MEM_ACCESS_CNT_EN is defined.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctlwb_in,
  input  logic [1:0]  ctlm_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rdata2_in,
  input  logic [4:0]  muxout_in,
  output logic [1:0]  ctlwb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  muxout_out,
  output logic        misalign_out
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt
`endif
);

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned CW    = 16;

  logic [DW-1:0] mem_q [DEPTH];

  logic [1:0]    ctlwb_q, ctlwb_d;
  logic [DW-1:0] read_data_q, read_data_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [4:0]    muxout_q, muxout_d;
  logic          misalign_q, misalign_d;

  logic          aligned_c;
  logic          misaligned_c;
  logic          rd_en_c;
  logic          wr_en_c;
  logic [AW-1:0] idx_c;

  // Access decode; upper address bits above [9:2] alias onto the same word.
  always_comb begin
    idx_c        = alu_result_in[9:2];
    aligned_c    = (alu_result_in[1:0] == 2'b00);
    misaligned_c = !aligned_c && (ctlm_in != 2'b00);
    rd_en_c      = aligned_c && ctlm_in[1];
    wr_en_c      = aligned_c && ctlm_in[0] && !rst;
  end

  // Next MEM/WB contents; memory read sees the pre-write word.
  always_comb begin
    ctlwb_d      = misaligned_c ? 2'b00 : ctlwb_in;
    read_data_d  = rd_en_c ? mem_q[idx_c] : '0;
    alu_result_d = alu_result_in;
    muxout_d     = muxout_in;
    misalign_d   = misaligned_c;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[idx_c] <= rdata2_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctlwb_q      <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      muxout_q     <= '0;
      misalign_q   <= 1'b0;
    end else begin
      ctlwb_q      <= ctlwb_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      muxout_q     <= muxout_d;
      misalign_q   <= misalign_d;
    end
  end

  assign ctlwb_out      = ctlwb_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign muxout_out     = muxout_q;
  assign misalign_out   = misalign_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] store_cnt_q, store_cnt_d;

  // Saturating counters of aligned accesses only.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (rd_en_c && (load_cnt_q != {CW{1'b1}})) begin
      load_cnt_d = load_cnt_q + CW'(1);
    end
    if (aligned_c && ctlm_in[0] && (store_cnt_q != {CW{1'b1}})) begin
      store_cnt_d = store_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a word-array reference model.
// Counter checks are compiled in when MEM_ACCESS_CNT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctlwb_in, ctlm_in;
  logic [31:0] alu_result_in, rdata2_in;
  logic [4:0]  muxout_in;
  logic [1:0]  ctlwb_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  muxout_out;
  logic        misalign_out;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] load_cnt, store_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [31:0] mem_m [256];
  logic [1:0]  exp_wb;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_mux;
  logic        exp_mis;
  int          exp_lc, exp_sc;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
    .alu_result_in(alu_result_in), .rdata2_in(rdata2_in),
    .muxout_in(muxout_in),
    .ctlwb_out(ctlwb_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .muxout_out(muxout_out),
    .misalign_out(misalign_out)
`ifdef MEM_ACCESS_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt)
`endif
  );

  // Drive one cycle, advance the model, and settle 1 time unit past the edge.
  task automatic step(input logic [1:0] wb, input logic [1:0] m,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [4:0] mux, input logic r);
    int idx;
    bit aligned;
    ctlwb_in = wb; ctlm_in = m; alu_result_in = addr;
    rdata2_in = data; muxout_in = mux; rst = r;
    idx = int'(addr[9:2]);
    aligned = (addr % 4) == 0;
    if (r) begin
      exp_wb = 0; exp_rd = 0; exp_alu = 0; exp_mux = 0; exp_mis = 0;
      exp_lc = 0; exp_sc = 0;
    end else begin
      exp_mis = !aligned && (m != 0);
      exp_wb  = exp_mis ? 2'b00 : wb;
      exp_alu = addr;
      exp_mux = mux;
      exp_rd  = (aligned && m[1]) ? mem_m[idx] : 32'h0;
      if (aligned && m[1] && exp_lc < 65535) exp_lc++;
      if (aligned && m[0] && exp_sc < 65535) exp_sc++;
      if (aligned && m[0]) mem_m[idx] = data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(2'b11, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
    step(2'b11, 2'b01, 32'h40, 32'h77, 5'd9, 1'b1);
    total_cnt++;
    if ({ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out} !== 72'h0)
      $display("FAIL reset_outputs got wb=%0h rd=%0h alu=%0h mux=%0h mis=%0b want all 0",
               ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out);
    else pass_cnt++;
`ifdef MEM_ACCESS_CNT_EN
    total_cnt++;
    if (load_cnt !== 16'h0 || store_cnt !== 16'h0)
      $display("FAIL reset_counters got %0h/%0h want 0/0", load_cnt, store_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_fill;
    bit ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(2'b10, 2'b01, 32'(i * 4), $urandom, 5'(i), 1'b0);
      if (misalign_out !== 1'b0 || ctlwb_out !== 2'b10 || alu_result_out !== 32'(i * 4)
          || read_data_out !== 32'h0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL fill_passthrough got wb=%0h rd=%0h mis=%0b want 2/0/0",
                      ctlwb_out, read_data_out, misalign_out);
    else pass_cnt++;
  endtask

  task automatic test_store_load;
    step(2'b10, 2'b01, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0);
    step(2'b01, 2'b10, 32'h10, 32'h0, 5'd7, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'hDEADBEEF) $display("FAIL store_load_data got %h want deadbeef", read_data_out);
    else pass_cnt++;
    total_cnt++;
    if (ctlwb_out !== 2'b01 || muxout_out !== 5'd7 || misalign_out !== 1'b0)
      $display("FAIL store_load_ctl got wb=%0h mux=%0d mis=%0b want 1/7/0", ctlwb_out, muxout_out, misalign_out);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle;
    step(2'b00, 2'b01, 32'h20, 32'h1111_1111, 5'd1, 1'b0);
    step(2'b11, 2'b11, 32'h20, 32'h2222_2222, 5'd2, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'h1111_1111) $display("FAIL rw_old_data got %h want 11111111", read_data_out);
    else pass_cnt++;
    step(2'b11, 2'b10, 32'h20, 32'h0, 5'd2, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'h2222_2222) $display("FAIL rw_new_data got %h want 22222222", read_data_out);
    else pass_cnt++;
  endtask

  task automatic test_misaligned;
    step(2'b00, 2'b01, 32'h10, 32'h1234_5678, 5'd0, 1'b0);
    step(2'b11, 2'b01, 32'h13, 32'hA5A5A5A5, 5'd4, 1'b0);
    total_cnt++;
    if (misalign_out !== 1'b1 || ctlwb_out !== 2'b00)
      $display("FAIL misalign_flag got mis=%0b wb=%0h want 1/0", misalign_out, ctlwb_out);
    else pass_cnt++;
    total_cnt++;
    if (alu_result_out !== 32'h13 || muxout_out !== 5'd4 || read_data_out !== 32'h0)
      $display("FAIL misalign_pass got alu=%h mux=%0d rd=%h want 13/4/0", alu_result_out, muxout_out, read_data_out);
    else pass_cnt++;
    step(2'b11, 2'b10, 32'h12, 32'h0, 5'd4, 1'b0);
    total_cnt++;
    if (misalign_out !== 1'b1 || read_data_out !== 32'h0)
      $display("FAIL misalign_load got mis=%0b rd=%h want 1/0", misalign_out, read_data_out);
    else pass_cnt++;
    step(2'b11, 2'b10, 32'h10, 32'h0, 5'd4, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'h1234_5678 || misalign_out !== 1'b0 || ctlwb_out !== 2'b11)
      $display("FAIL misalign_no_write got rd=%h mis=%0b wb=%0h want 12345678/0/3",
               read_data_out, misalign_out, ctlwb_out);
    else pass_cnt++;
  endtask

  task automatic test_alias;
    step(2'b01, 2'b01, 32'h404, 32'h0000_00FF, 5'd5, 1'b0);
    step(2'b01, 2'b10, 32'h004, 32'h0, 5'd5, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'h0000_00FF) $display("FAIL alias_read got %h want 000000ff", read_data_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    step(2'b00, 2'b01, 32'h30, 32'hCAFE_F00D, 5'd0, 1'b0);
    step(2'b11, 2'b10, 32'h30, 32'h0, 5'd8, 1'b0);
    step(2'b11, 2'b11, 32'h30, 32'h0BAD_0BAD, 5'h1F, 1'b1);
    total_cnt++;
    if ({ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out} !== 72'h0)
      $display("FAIL reset_mid_outputs got wb=%0h rd=%h alu=%h mux=%0h mis=%0b want all 0",
               ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out);
    else pass_cnt++;
`ifdef MEM_ACCESS_CNT_EN
    total_cnt++;
    if (load_cnt !== 16'h0 || store_cnt !== 16'h0)
      $display("FAIL reset_mid_counters got %0h/%0h want 0/0", load_cnt, store_cnt);
    else pass_cnt++;
`endif
    step(2'b10, 2'b10, 32'h30, 32'h0, 5'd6, 1'b0);
    total_cnt++;
    if (read_data_out !== 32'hCAFE_F00D || ctlwb_out !== 2'b10 || muxout_out !== 5'd6)
      $display("FAIL reset_mid_retain got rd=%h wb=%0h mux=%0d want cafef00d/2/6",
               read_data_out, ctlwb_out, muxout_out);
    else pass_cnt++;
`ifdef MEM_ACCESS_CNT_EN
    total_cnt++;
    if (load_cnt !== 16'd1 || store_cnt !== 16'd0)
      $display("FAIL reset_mid_count_after got %0d/%0d want 1/0", load_cnt, store_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random;
    logic [31:0] addr;
    for (int i = 0; i < 400; i++) begin
      addr = $urandom;
      if ($urandom_range(3) != 0) addr[1:0] = 2'b00;
      step(2'($urandom), 2'($urandom), addr, $urandom, 5'($urandom), ($urandom_range(31) == 0));
      total_cnt++;
      if ({ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out} !==
          {exp_wb, exp_rd, exp_alu, exp_mux, exp_mis})
        $display("FAIL random_%0d got wb=%0h rd=%h alu=%h mux=%0h mis=%0b want wb=%0h rd=%h alu=%h mux=%0h mis=%0b",
                 i, ctlwb_out, read_data_out, alu_result_out, muxout_out, misalign_out,
                 exp_wb, exp_rd, exp_alu, exp_mux, exp_mis);
      else pass_cnt++;
`ifdef MEM_ACCESS_CNT_EN
      total_cnt++;
      if (load_cnt !== 16'(exp_lc) || store_cnt !== 16'(exp_sc))
        $display("FAIL random_cnt_%0d got %0d/%0d want %0d/%0d", i, load_cnt, store_cnt, exp_lc, exp_sc);
      else pass_cnt++;
`endif
    end
  endtask

`ifdef MEM_ACCESS_CNT_EN
  task automatic test_saturation;
    step(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
    for (int i = 0; i < 65540; i++) step(2'b01, 2'b10, 32'(($urandom % 256) * 4), 32'h0, 5'd1, 1'b0);
    total_cnt++;
    if (load_cnt !== 16'hFFFF || store_cnt !== 16'h0)
      $display("FAIL saturation got %h/%h want ffff/0000", load_cnt, store_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_store_load;
    test_same_cycle;
    test_misaligned;
    test_alias;
    test_reset_mid;
    test_random;
`ifdef MEM_ACCESS_CNT_EN
    test_saturation;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
